tlb_refill_walker: RTL

//  Refill engine that feeds the write side of the direct-mapped TLB. On a user-mode miss it

---
 rtl/tlb_refill_walker.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker
//
// Refill engine for the write side of the direct-mapped TLB. On a user-mode miss, the
// walker reads one PTE from a linear page table at ptbr + (vpn << 2). It then either
// pulses tlb_write with the translated page or pulses page_fault. busy stays high for the
// whole walk so that the pipeline is held.
//
// Optional feature: define PTW_TIMEOUT_EN to bound the wait for the PTE read. The wait
// length is TIMEOUT_CYCLES. Without the macro, FETCH waits for mem_ready indefinitely.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   mode            execution mode; misses in `SUPERVISOR_MODE are ignored
//   miss, vaddr     lookup miss this cycle and its virtual address
//   ptbr            page-table base (word aligned)
//   mem_req/addr    PTE read request; held stable until mem_ready
//   mem_ready/rdata read completion; rdata[31] = valid, rdata[PPN-1:0] = ppn
//   busy            walk in progress (stall)
//   tlb_write       one-cycle TLB write strobe with tlb_vaddr / tlb_paddr_new
//   page_fault      one-cycle pulse on invalid PTE or timeout
//   dbg_state       current FSM state (0 IDLE, 1 FETCH, 2 FILL, 3 FAULT)
//
// Handshake: mem_req rises with mem_addr valid. Both hold until an edge at which
// mem_ready=1. mem_rdata is consumed at that edge. mem_req drops on the same edge.
// All outputs are registered.

`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 20
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 20
`endif
`ifndef PAGE_SIZE
`define PAGE_SIZE 12
`endif
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef SUPERVISOR_MODE
`define SUPERVISOR_MODE 2'b11
`endif

module tlb_refill_walker #(
    parameter int VADDR_WIDTH    = `VIRTUAL_ADDR_WIDTH,
    parameter int PADDR_WIDTH    = `PHYSICAL_ADDR_WIDTH,
    parameter int PAGE_BITS      = `PAGE_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`MODE_WIDTH-1:0] mode,
    input  logic                   miss,
    input  logic [VADDR_WIDTH-1:0] vaddr,
    input  logic [PADDR_WIDTH-1:0] ptbr,
    output logic                   mem_req,
    output logic [PADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,
    output logic                   busy,
    output logic                   tlb_write,
    output logic [VADDR_WIDTH-1:0] tlb_vaddr,
    output logic [PADDR_WIDTH-1:0] tlb_paddr_new,
    output logic                   page_fault,
    output logic [1:0]             dbg_state
);

    localparam int VPN_W = VADDR_WIDTH - PAGE_BITS;
    localparam int PPN_W = PADDR_WIDTH - PAGE_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FILL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [VADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic                   mem_req_d;
    logic [PADDR_WIDTH-1:0] mem_addr_d;
    logic                   busy_d;
    logic                   tlb_write_d;
    logic [VADDR_WIDTH-1:0] tlb_vaddr_d;
    logic [PADDR_WIDTH-1:0] tlb_paddr_d;
    logic                   page_fault_d;

    logic                   user_miss;
    logic                   pte_valid;
    logic                   timeout_hit;
    logic [VPN_W+1:0]       vpn_off;
    logic [PADDR_WIDTH-1:0] pte_addr;
    logic [PADDR_WIDTH-1:0] fill_paddr;

    assign user_miss  = miss && (mode != `SUPERVISOR_MODE);
    assign pte_valid  = mem_rdata[31];
    // The sum is truncated to PADDR_WIDTH, so a table near the top of memory wraps.
    assign vpn_off    = {vaddr[VADDR_WIDTH-1:PAGE_BITS], 2'b00};
    assign pte_addr   = ptbr + PADDR_WIDTH'(vpn_off);
    assign fill_paddr = {mem_rdata[PPN_W-1:0], {PAGE_BITS{1'b0}}};
    assign dbg_state  = state_q;

`ifdef PTW_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter sits at zero in IDLE, so it is already cleared on FETCH entry.
    // In FETCH it counts the cycles that end without mem_ready.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q == S_FETCH && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // PTE attribute bits other than valid are not used by this TLB.
    logic unused_bits;
    assign unused_bits = ^{mem_rdata[30:PPN_W], 1'(TIMEOUT_CYCLES)};

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vaddr_q       <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            busy          <= 1'b0;
            tlb_write     <= 1'b0;
            tlb_vaddr     <= '0;
            tlb_paddr_new <= '0;
            page_fault    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            mem_req       <= mem_req_d;
            mem_addr      <= mem_addr_d;
            busy          <= busy_d;
            tlb_write     <= tlb_write_d;
            tlb_vaddr     <= tlb_vaddr_d;
            tlb_paddr_new <= tlb_paddr_d;
            page_fault    <= page_fault_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (user_miss) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A ready arriving on the timeout edge still completes the walk.
                if (mem_ready) begin
                    state_d = pte_valid ? S_FILL : S_FAULT;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_FILL:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        vaddr_d      = vaddr_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        busy_d       = busy;
        tlb_write_d  = 1'b0;
        tlb_vaddr_d  = tlb_vaddr;
        tlb_paddr_d  = tlb_paddr_new;
        page_fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (user_miss) begin
                    vaddr_d    = vaddr;
                    mem_addr_d = pte_addr;
                    mem_req_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (pte_valid) begin
                        tlb_write_d = 1'b1;
                        tlb_vaddr_d = vaddr_q;
                        tlb_paddr_d = fill_paddr;
                    end else begin
                        page_fault_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mem_req_d    = 1'b0;
                    page_fault_d = 1'b1;
                end
            end
            S_FILL, S_FAULT: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule
